dflipflop_serial_tx: RTL
========================

DFLIPFLOP_SERIAL_TX -- requirements
Module: dflipflop_serial_tx

Interface
REQ-001 SHALL provide parameter DATA_W, default 8, payload width in bits (legal range 1..16).
REQ-002 SHALL provide parameter BIT_CYCLES, default 4, clock cycles per transmitted bit (legal range 1..255).
REQ-003 SHALL provide port input_clock1_clk_1  in  1  single system clock; all state changes on its rising edge.
REQ-004 SHALL provide port input_reset1_rst_n_2  in  1  reset, asynchronous, active-low.
REQ-005 SHALL provide port input_switch_data_3  in  DATA_W  parallel payload to transmit.
REQ-006 SHALL provide port input_button_valid_4  in  1  request to transmit the payload.
REQ-007 SHALL provide port output_led_ready_5  out  1  block can accept a payload this cycle.
REQ-008 SHALL provide port output_led_txd_6  out  1  serial line, idle high.
REQ-009 SHALL provide port output_led_busy_7  out  1  frame in progress.

Function
REQ-010 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP; PARITY exists only per REQ-027.
REQ-011 SHALL drive ready = 1 only in IDLE; busy = NOT ready; outputs registered or decoded from registered state, no combinational path from any input.
REQ-012 SHALL accept a payload on a rising edge where valid = 1 and ready = 1, capturing input_switch_data_3 into an internal shift register on that edge.
REQ-013 SHALL transition IDLE -> START on acceptance; txd = 0 from the next cycle (latency 1 cycle from accepting edge to start bit).
REQ-014 SHALL hold each bit on txd for exactly BIT_CYCLES cycles using a bit-period counter that resets to 0 on every bit boundary.
REQ-015 SHALL, in DATA, shift out DATA_W bits LSB first, tracking position with a bit index counter of width ceil(log2(DATA_W+1)).
REQ-016 SHALL transition DATA -> PARITY (when compiled in) or DATA -> STOP after bit DATA_W-1 completes its period.
REQ-017 SHALL drive txd = 1 in STOP for BIT_CYCLES cycles, then return to IDLE; ready = 1 on the first cycle after the stop period.
REQ-018 SHALL make frame length exactly (DATA_W + 2) * BIT_CYCLES cycles (+BIT_CYCLES with parity), start bit to end of stop bit.
REQ-019 SHALL ignore valid and input_switch_data_3 while busy; input changes mid-frame SHALL NOT alter transmitted bits.
REQ-020 SHALL allow back-to-back frames: valid held high produces a new start bit 1 cycle after ready rises, no extra idle gap.
REQ-021 SHALL drive txd = 1 in IDLE and whenever not in START/DATA/PARITY.
REQ-022 SHALL treat BIT_CYCLES = 1 as one cycle per bit with no counter wrap anomalies.

Reset
REQ-023 SHALL, on input_reset1_rst_n_2 = 0, immediately (asynchronously) set state = IDLE, txd = 1, ready = 1, busy = 0, counters and shift register = 0.
REQ-024 SHALL abort a frame in progress on reset without completing remaining bits; no partial stop bit is generated.
REQ-025 SHALL not accept a payload on the first rising edge at which reset is deasserted only if reset is still low at that edge; acceptance resumes on the next edge with reset high.

Configuration
REQ-026 SHALL recognise preprocessor macro DFLIPFLOP_SERIAL_TX_PARITY_EN.
REQ-027 SHALL, when DFLIPFLOP_SERIAL_TX_PARITY_EN is defined, insert state PARITY after DATA transmitting even parity (XOR of all DATA_W payload bits) for BIT_CYCLES cycles.
REQ-028 SHALL, when DFLIPFLOP_SERIAL_TX_PARITY_EN is undefined, contain no PARITY state or parity logic; DATA proceeds directly to STOP.

Verification
REQ-029 SHALL cover: reset low then high, no valid -> txd = 1, ready = 1, busy = 0 indefinitely.
REQ-030 SHALL cover: defaults, no parity, send 0xA5 -> txd per 4-cycle period: 0,1,0,1,0,0,1,0,1,1; busy high 40 cycles; ready returns cycle 41.
REQ-031 SHALL cover: parity build, send 0x07 -> data bits 1,1,1,0,0,0,0,0 then parity 1 then stop 1; frame 44 cycles.
REQ-032 SHALL cover: send 0x3C, change data to 0xFF and pulse valid mid-frame -> transmitted bits remain 0x3C pattern, second valid ignored.
REQ-033 SHALL cover: valid held high with 0x01 then 0x80 -> two frames, second start bit 1 cycle after ready rises, no gap beyond that.
REQ-034 SHALL cover: reset asserted during data bit 3 of 0x55 -> txd = 1 and ready = 1 immediately, no further bits emitted.

Source files
------------

// File: rtl/dflipflop_serial_tx.sv
// Parallel-to-serial frame transmitter: start bit, DATA_W bits LSB first, stop bit.
// Optional even-parity bit enabled by defining DFLIPFLOP_SERIAL_TX_PARITY_EN.
module dflipflop_serial_tx #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned BIT_CYCLES = 4
) (
  input  logic              input_clock1_clk_1,
  input  logic              input_reset1_rst_n_2,
  input  logic [DATA_W-1:0] input_switch_data_3,
  input  logic              input_button_valid_4,
  output logic              output_led_ready_5,
  output logic              output_led_txd_6,
  output logic              output_led_busy_7
);

  localparam int unsigned IDX_W = $clog2(DATA_W + 1);
  localparam int unsigned CNT_W = 8;

`ifdef DFLIPFLOP_SERIAL_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t            state, state_next;
  logic [CNT_W-1:0]  cnt;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] shreg;
  logic              accept, bit_end, last_bit;

  assign accept   = (state == IDLE) && input_button_valid_4;
  assign bit_end  = (cnt == CNT_W'(BIT_CYCLES - 1));
  assign last_bit = (idx == IDX_W'(DATA_W - 1));

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:  if (input_button_valid_4) state_next = START;
      START: if (bit_end) state_next = DATA;
`ifdef DFLIPFLOP_SERIAL_TX_PARITY_EN
      DATA:   if (bit_end && last_bit) state_next = PARITY;
      PARITY: if (bit_end) state_next = STOP;
`else
      DATA:   if (bit_end && last_bit) state_next = STOP;
`endif
      STOP:  if (bit_end) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge input_clock1_clk_1 or negedge input_reset1_rst_n_2) begin
    if (!input_reset1_rst_n_2) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      shreg <= '0;
    end else begin
      state <= state_next;
      // Period counter idles at zero so every bit, including the start bit, gets a full period.
      if (state == IDLE || bit_end) cnt <= '0;
      else                          cnt <= cnt + CNT_W'(1);
      if (state != DATA)  idx <= '0;
      else if (bit_end)   idx <= idx + IDX_W'(1);
      if (accept)                          shreg <= input_switch_data_3;
      else if (state == DATA && bit_end)   shreg <= shreg >> 1;
    end
  end

`ifdef DFLIPFLOP_SERIAL_TX_PARITY_EN
  logic par;

  always_ff @(posedge input_clock1_clk_1 or negedge input_reset1_rst_n_2) begin
    if (!input_reset1_rst_n_2) par <= 1'b0;
    else if (accept)           par <= ^input_switch_data_3;
  end
`endif

  always_comb begin
    output_led_txd_6 = 1'b1;
    unique case (state)
      START:  output_led_txd_6 = 1'b0;
      DATA:   output_led_txd_6 = shreg[0];
`ifdef DFLIPFLOP_SERIAL_TX_PARITY_EN
      PARITY: output_led_txd_6 = par;
`endif
      default: output_led_txd_6 = 1'b1;
    endcase
  end

  assign output_led_ready_5 = (state == IDLE);
  assign output_led_busy_7  = (state != IDLE);

endmodule
